// File: rtl/score_display_scan_pkg.sv
// ============================================================================
//  Module  : score_display_scan_pkg
//  Purpose : Shared types and 7-segment constants for the Pong score display.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package score_display_scan_pkg;

  // Segment patterns {g,f,e,d,c,b,a}, active low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Slot index equals the anode bit it drives
  localparam logic [1:0] SLOT_RO = 2'd0;
  localparam logic [1:0] SLOT_RT = 2'd1;
  localparam logic [1:0] SLOT_LO = 2'd2;
  localparam logic [1:0] SLOT_LT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV_L = 2'd1,
    ST_CONV_R = 2'd2,
    ST_COMMIT = 2'd3
  } conv_state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bin8_to_bcd_seq.sv
// ============================================================================
//  Module  : bin8_to_bcd_seq
//  Purpose : Sequential shift-add-3 converter, 8 shift cycles then 1 done cycle.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bin8_to_bcd_seq (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [7:0] r_bin;
  logic [9:0] r_bcd;
  logic [2:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic [8:0] w_adj;

  // The hundreds digit never exceeds 2, so it never needs correction
  always_comb begin
    w_adj = r_bcd[8:0];
    if (r_bcd[3:0] >= 4'd5) w_adj[3:0] = r_bcd[3:0] + 4'd3;
    if (r_bcd[7:4] >= 4'd5) w_adj[7:4] = r_bcd[7:4] + 4'd3;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_bin  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        r_bcd <= {w_adj, r_bin[7]};
        r_bin <= {r_bin[6:0], 1'b0};
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (start) begin
        r_bin  <= bin;
        r_bcd  <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign hundreds = r_bcd[9:8];
  assign tens     = r_bcd[7:4];
  assign ones     = r_bcd[3:0];

endmodule

`default_nettype wire

// File: rtl/score_display_scan.sv
// ============================================================================
//  Module  : score_display_scan
//  Purpose : 4-digit multiplexed 7-segment score display with per-frame
//            BCD snapshot and winner blink.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module score_display_scan
  import score_display_scan_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] L_Dig,
  input  logic [7:0] R_Dig,
  input  logic       winner,
  input  logic       mode,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] c_SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] c_BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] r_slot_cnt;
  logic [1:0]    r_slot;
  logic          r_started;
  logic          r_frame_tick;
  logic [7:0]    r_snap_r;
  logic [9:0]    r_pend_l;
  logic [9:0]    r_disp_l;
  logic [9:0]    r_disp_r;
  logic [BW-1:0] r_blink_cnt;
  logic          r_phase;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  conv_state_t   r_state;

  conv_state_t   w_state_nxt;
  logic          w_slot_tick;
  logic          w_wrap;
  logic          w_frame_start;
  logic          w_cv_start;
  logic [7:0]    w_cv_bin;
  logic          w_snap;
  logic          w_cap_l;
  logic          w_commit;
  logic          w_cv_busy;
  logic          w_cv_done;
  logic [1:0]    w_cv_h;
  logic [3:0]    w_cv_t;
  logic [3:0]    w_cv_o;
  logic [9:0]    w_side;
  logic [3:0]    w_an;
  logic [6:0]    w_seg;
  logic          w_dp;

  assign w_slot_tick   = (r_slot_cnt == c_SLOT_LAST);
  assign w_wrap        = w_slot_tick && (r_slot == SLOT_LT);
  assign w_frame_start = w_wrap || !r_started;

  bin8_to_bcd_seq u_bcd (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (w_cv_start),
    .bin      (w_cv_bin),
    .busy     (w_cv_busy),
    .done     (w_cv_done),
    .hundreds (w_cv_h),
    .tens     (w_cv_t),
    .ones     (w_cv_o)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // L is converted straight from the input port on the frame-start cycle; R is held
  always_comb begin
    w_state_nxt = r_state;
    w_cv_start  = 1'b0;
    w_cv_bin    = L_Dig;
    w_snap      = 1'b0;
    w_cap_l     = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_frame_start && !w_cv_busy) begin
          w_cv_start  = 1'b1;
          w_snap      = 1'b1;
          w_state_nxt = ST_CONV_L;
        end
      end
      ST_CONV_L: begin
        if (w_cv_done) begin
          w_cap_l     = 1'b1;
          w_cv_start  = 1'b1;
          w_cv_bin    = r_snap_r;
          w_state_nxt = ST_CONV_R;
        end
      end
      ST_CONV_R: begin
        if (w_cv_done) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_slot_cnt   <= '0;
      r_slot       <= 2'd0;
      r_started    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_snap_r     <= '0;
      r_pend_l     <= '0;
      r_disp_l     <= '0;
      r_disp_r     <= '0;
      r_blink_cnt  <= '0;
      r_phase      <= 1'b1;
    end else begin
      r_started    <= 1'b1;
      r_frame_tick <= w_wrap;
      r_slot_cnt   <= w_slot_tick ? '0 : r_slot_cnt + 1'b1;
      if (w_slot_tick) r_slot <= r_slot + 2'd1;
      if (w_snap)      r_snap_r <= R_Dig;
      if (w_cap_l)     r_pend_l <= {w_cv_h, w_cv_t, w_cv_o};
      if (w_commit) begin
        r_disp_l <= r_pend_l;
        r_disp_r <= {w_cv_h, w_cv_t, w_cv_o};
      end
      if (!winner) begin
        r_blink_cnt <= '0;
        r_phase     <= 1'b1;
      end else if (w_wrap) begin
        if (r_blink_cnt == c_BLINK_LAST) begin
          r_blink_cnt <= '0;
          r_phase     <= !r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end
    end
  end

  assign w_side = r_slot[1] ? r_disp_l : r_disp_r;

  always_comb begin
    w_an  = ~(4'b0001 << r_slot);
    w_seg = seg_of(r_slot[0] ? w_side[7:4] : w_side[3:0]);
    w_dp  = !((r_slot == SLOT_LO) && mode);
    if (w_side[9:8] != 2'd0) begin
      w_seg = SEG_DASH;
    end else if (r_slot[0] && (w_side[7:4] == 4'd0)) begin
      w_an  = 4'hF;
      w_seg = SEG_BLANK;
    end
    if (!r_phase) begin
      w_an  = 4'hF;
      w_seg = SEG_BLANK;
      w_dp  = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_an  <= 4'hF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire
